// File: rtl/host_mem_serdes_pkg.sv
// Shared types and helpers for the host-link memory-backup bridge.
// Header layout on the narrow link is {tag, addr, rw} with rw at bit 0.
package host_mem_serdes_pkg;

    typedef enum logic [1:0] {
        RX_HDR,
        CMD,
        RX_DATA,
        DATA_OUT
    } req_state_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int hdr_bits(input int aw, input int tw);
        return 1 + aw + tw;
    endfunction

    function automatic int hdr_tag_lsb(input int aw);
        return 1 + aw;
    endfunction

endpackage

// File: rtl/host_mem_serdes_if.sv
// Bundle of narrow-link and wide-memory handshakes around the bridge.
// slave = bridge side, master = host/memory environment side.
interface host_mem_serdes_if #(
    parameter int NW = 16,
    parameter int DW = 128,
    parameter int AW = 26,
    parameter int TW = 5
);
    import host_mem_serdes_pkg::*;

    logic          narrow_req_valid;
    logic          narrow_req_ready;
    logic [NW-1:0] narrow_req_bits;
    logic          narrow_resp_valid;
    logic          narrow_resp_ready;
    logic [NW-1:0] narrow_resp_bits;
    logic          wide_req_cmd_valid;
    logic          wide_req_cmd_ready;
    logic          wide_req_cmd_rw;
    logic [AW-1:0] wide_req_cmd_addr;
    logic [TW-1:0] wide_req_cmd_tag;
    logic          wide_req_data_valid;
    logic          wide_req_data_ready;
    logic [DW-1:0] wide_req_data_bits;
    logic          wide_resp_valid;
    logic          wide_resp_ready;
    logic [DW-1:0] wide_resp_data;
    logic [TW-1:0] wide_resp_tag;

    modport slave (
        input  narrow_req_valid, narrow_req_bits, narrow_resp_ready,
        input  wide_req_cmd_ready, wide_req_data_ready,
        input  wide_resp_valid, wide_resp_data, wide_resp_tag,
        output narrow_req_ready, narrow_resp_valid, narrow_resp_bits,
        output wide_req_cmd_valid, wide_req_cmd_rw, wide_req_cmd_addr, wide_req_cmd_tag,
        output wide_req_data_valid, wide_req_data_bits, wide_resp_ready
    );

    modport master (
        output narrow_req_valid, narrow_req_bits, narrow_resp_ready,
        output wide_req_cmd_ready, wide_req_data_ready,
        output wide_resp_valid, wide_resp_data, wide_resp_tag,
        input  narrow_req_ready, narrow_resp_valid, narrow_resp_bits,
        input  wide_req_cmd_valid, wide_req_cmd_rw, wide_req_cmd_addr, wide_req_cmd_tag,
        input  wide_req_data_valid, wide_req_data_bits, wide_resp_ready
    );

endinterface

// File: rtl/host_mem_serdes_fifo.sv
// Synchronous FIFO, DEPTH a power of 2, head visible the cycle after push.
// Latency 1 cycle push-to-empty-clear; push ignored when full, pop ignored when empty.
// Full/empty derived from pointers carrying one extra wrap bit.
module host_mem_serdes_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PW   = $clog2(DEPTH);
    localparam int PTRW = PW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("host_mem_serdes_fifo: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_ptr_q, wr_ptr_d;
    logic [PW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign full     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem_q[rd_ptr_q[PW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTRW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTRW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/host_mem_serdes.sv
// Narrow-link <-> wide-memory bridge; HOST_MEM_SERDES_RESP_TAG_EN prefixes each response beat with a tag flit.
// Latency: cmd/data valid 1 cycle after last flit accepted; response head loads 1 cycle after visible.
// Backpressure: narrow_req_ready low in CMD/DATA_OUT; wide_resp_ready = !fifo full; narrow_resp held until ready.
module host_mem_serdes
    import host_mem_serdes_pkg::*;
#(
    parameter int NW         = 16,
    parameter int DW         = 128,
    parameter int AW         = 26,
    parameter int TW         = 5,
    parameter int DATA_BEATS = 4,
    parameter int RESP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    host_mem_serdes_if.slave bus
);
    localparam int HB      = hdr_bits(AW, TW);
    localparam int HF      = ceil_div(HB, NW);
    localparam int HPW     = HF * NW;
    localparam int DF      = DW / NW;
    localparam int TAG_LSB = hdr_tag_lsb(AW);
`ifdef HOST_MEM_SERDES_RESP_TAG_EN
    localparam int TF      = 1;
`else
    localparam int TF      = 0;
`endif
    localparam int RF      = DF + TF;
    localparam int RSW     = RF * NW;
    localparam int MAXF    = (HF > RF) ? HF : RF;
    localparam int CW      = $clog2(MAXF + 1);
    localparam int BW      = $clog2(DATA_BEATS + 1);

    generate
        if (DW % NW != 0) begin : g_bad_dw
            $error("host_mem_serdes: DW must be a multiple of NW");
        end
        if (TF == 1 && TW > NW) begin : g_bad_tw
            $error("host_mem_serdes: TW must not exceed NW when tag flits are emitted");
        end
    endgenerate

    req_state_e     state_q, state_d;
    logic [HPW-1:0] hdr_q, hdr_d;
    logic [DW-1:0]  data_q, data_d;
    logic [CW-1:0]  flit_cnt_q, flit_cnt_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic           req_rdy, req_fire;

    assign req_rdy  = (state_q == RX_HDR) || (state_q == RX_DATA);
    assign req_fire = bus.narrow_req_valid && req_rdy;

    // Both collectors shift right so the first flit ends up in the LSBs.
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        data_d     = data_q;
        flit_cnt_d = flit_cnt_q;
        beat_d     = beat_q;
        unique case (state_q)
            RX_HDR: begin
                if (req_fire) begin
                    hdr_d = HPW'({bus.narrow_req_bits, hdr_q} >> NW);
                    if (flit_cnt_q == CW'(HF - 1)) begin
                        flit_cnt_d = '0;
                        state_d    = CMD;
                    end else begin
                        flit_cnt_d = flit_cnt_q + CW'(1);
                    end
                end
            end
            CMD: begin
                if (bus.wide_req_cmd_ready) begin
                    beat_d  = '0;
                    state_d = hdr_q[0] ? RX_DATA : RX_HDR;
                end
            end
            RX_DATA: begin
                if (req_fire) begin
                    data_d = DW'({bus.narrow_req_bits, data_q} >> NW);
                    if (flit_cnt_q == CW'(DF - 1)) begin
                        flit_cnt_d = '0;
                        state_d    = DATA_OUT;
                    end else begin
                        flit_cnt_d = flit_cnt_q + CW'(1);
                    end
                end
            end
            DATA_OUT: begin
                if (bus.wide_req_data_ready) begin
                    if (beat_q == BW'(DATA_BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = RX_HDR;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                        state_d = RX_DATA;
                    end
                end
            end
            default: state_d = RX_HDR;
        endcase
    end

    assign bus.narrow_req_ready    = req_rdy;
    assign bus.wide_req_cmd_valid  = (state_q == CMD);
    assign bus.wide_req_cmd_rw     = hdr_q[0];
    assign bus.wide_req_cmd_addr   = hdr_q[AW:1];
    assign bus.wide_req_cmd_tag    = hdr_q[HB-1:TAG_LSB];
    assign bus.wide_req_data_valid = (state_q == DATA_OUT);
    assign bus.wide_req_data_bits  = data_q;

    logic               fifo_full, fifo_empty, fifo_pop;
    logic [TW+DW-1:0]   fifo_head;
    logic               rsp_busy_q, rsp_busy_d;
    logic [RSW-1:0]     rsp_sr_q, rsp_sr_d, rsp_load;
    logic [CW-1:0]      rsp_cnt_q, rsp_cnt_d;

    assign bus.wide_resp_ready = !fifo_full;

    host_mem_serdes_fifo #(
        .WIDTH (TW + DW),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .rst_n    (reset_n),
        .push     (bus.wide_resp_valid),
        .push_dat ({bus.wide_resp_tag, bus.wide_resp_data}),
        .pop      (fifo_pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

`ifdef HOST_MEM_SERDES_RESP_TAG_EN
    assign rsp_load = {fifo_head[DW-1:0], NW'(fifo_head[TW+DW-1:DW])};
`else
    logic [TW-1:0] rsp_tag_unused;
    assign rsp_tag_unused = fifo_head[TW+DW-1:DW];
    assign rsp_load       = fifo_head[DW-1:0];
`endif

    // Loading only when idle gives the one-cycle bubble between entries.
    assign fifo_pop = !rsp_busy_q && !fifo_empty;

    always_comb begin
        rsp_busy_d = rsp_busy_q;
        rsp_sr_d   = rsp_sr_q;
        rsp_cnt_d  = rsp_cnt_q;
        if (fifo_pop) begin
            rsp_busy_d = 1'b1;
            rsp_sr_d   = rsp_load;
            rsp_cnt_d  = '0;
        end else if (rsp_busy_q && bus.narrow_resp_ready) begin
            rsp_sr_d = rsp_sr_q >> NW;
            if (rsp_cnt_q == CW'(RF - 1)) begin
                rsp_busy_d = 1'b0;
                rsp_cnt_d  = '0;
            end else begin
                rsp_cnt_d  = rsp_cnt_q + CW'(1);
            end
        end
    end

    assign bus.narrow_resp_valid = rsp_busy_q;
    assign bus.narrow_resp_bits  = rsp_sr_q[NW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RX_HDR;
            hdr_q      <= '0;
            data_q     <= '0;
            flit_cnt_q <= '0;
            beat_q     <= '0;
            rsp_busy_q <= 1'b0;
            rsp_sr_q   <= '0;
            rsp_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hdr_q      <= hdr_d;
            data_q     <= data_d;
            flit_cnt_q <= flit_cnt_d;
            beat_q     <= beat_d;
            rsp_busy_q <= rsp_busy_d;
            rsp_sr_q   <= rsp_sr_d;
            rsp_cnt_q  <= rsp_cnt_d;
        end
    end

endmodule

// File: tb/tb_host_mem_serdes.sv
// Bench for host_mem_serdes: directed cases plus randomized traffic against a transaction-level model.
module tb_host_mem_serdes;
    localparam int NW = 16, DW = 128, AW = 26, TW = 5, DATA_BEATS = 4, RESP_DEPTH = 4;
    localparam int DF  = DW / NW;
    localparam int HBW = 1 + AW + TW;
    localparam int HF  = (HBW + NW - 1) / NW;
    localparam int HPW = HF * NW;
`ifdef HOST_MEM_SERDES_RESP_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    host_mem_serdes_if #(.NW(NW), .DW(DW), .AW(AW), .TW(TW)) bus ();

    host_mem_serdes #(
        .NW(NW), .DW(DW), .AW(AW), .TW(TW), .DATA_BEATS(DATA_BEATS), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observed transfers and the model's expectations.
    logic [HBW-1:0] cmd_got[$], cmd_exp[$];
    logic [DW-1:0]  dat_got[$], dat_exp[$];
    logic [NW-1:0]  rfl_got[$], rfl_exp[$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.wide_req_cmd_valid && bus.wide_req_cmd_ready)
                cmd_got.push_back({bus.wide_req_cmd_tag, bus.wide_req_cmd_addr, bus.wide_req_cmd_rw});
            if (bus.wide_req_data_valid && bus.wide_req_data_ready)
                dat_got.push_back(bus.wide_req_data_bits);
            if (bus.narrow_resp_valid && bus.narrow_resp_ready)
                rfl_got.push_back(bus.narrow_resp_bits);
        end
    end

    logic rnd_mode = 1'b0;
    logic tog_mode = 1'b0;
    always begin
        @(posedge clk);
        #1;
        if (tog_mode) bus.narrow_resp_ready = ~bus.narrow_resp_ready;
        if (rnd_mode) begin
            bus.wide_req_cmd_ready  = ($urandom_range(0, 2) != 0);
            bus.wide_req_data_ready = ($urandom_range(0, 2) != 0);
            bus.narrow_resp_ready   = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_flit(input logic [NW-1:0] f);
        int n = 0;
        bus.narrow_req_valid = 1'b1;
        bus.narrow_req_bits  = f;
        @(negedge clk);
        while (!bus.narrow_req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("req_flit_timeout", bus.narrow_req_ready, 1);
        @(posedge clk);
        #1;
        bus.narrow_req_valid = 1'b0;
    endtask

    task automatic do_req(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                          input logic [DW-1:0] b [DATA_BEATS]);
        logic [HPW-1:0] h;
        h = HPW'({tag, addr, rw});
        cmd_exp.push_back({tag, addr, rw});
        for (int i = 0; i < HF; i++) send_flit(h[i*NW +: NW]);
        if (rw) begin
            for (int k = 0; k < DATA_BEATS; k++) begin
                dat_exp.push_back(b[k]);
                for (int i = 0; i < DF; i++) send_flit(b[k][i*NW +: NW]);
            end
        end
    endtask

    task automatic push_resp(input logic [TW-1:0] tag, input logic [DW-1:0] d);
        int n = 0;
        bus.wide_resp_valid = 1'b1;
        bus.wide_resp_tag   = tag;
        bus.wide_resp_data  = d;
        @(negedge clk);
        while (!bus.wide_resp_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("resp_push_timeout", bus.wide_resp_ready, 1);
        @(posedge clk);
        #1;
        bus.wide_resp_valid = 1'b0;
        if (TAG_EN) rfl_exp.push_back(NW'(tag));
        for (int i = 0; i < DF; i++) rfl_exp.push_back(d[i*NW +: NW]);
    endtask

    function automatic logic [DW-1:0] rnd_wide();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clear_queues();
        cmd_got.delete(); cmd_exp.delete();
        dat_got.delete(); dat_exp.delete();
        rfl_got.delete(); rfl_exp.delete();
    endtask

    task automatic drain_and_compare(input string tag);
        int n = 0;
        while ((cmd_got.size() < cmd_exp.size() || dat_got.size() < dat_exp.size() ||
                rfl_got.size() < rfl_exp.size()) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        chk({tag, "_ncmd"}, cmd_got.size(), cmd_exp.size());
        chk({tag, "_ndat"}, dat_got.size(), dat_exp.size());
        chk({tag, "_nrfl"}, rfl_got.size(), rfl_exp.size());
        foreach (cmd_exp[i]) if (i < cmd_got.size()) chk({tag, "_cmd"}, cmd_got[i], cmd_exp[i]);
        foreach (dat_exp[i]) if (i < dat_got.size()) chk({tag, "_dat"}, dat_got[i], dat_exp[i]);
        foreach (rfl_exp[i]) if (i < rfl_got.size()) chk({tag, "_rfl"}, rfl_got[i], rfl_exp[i]);
        clear_queues();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_requests(input int n);
        logic [DW-1:0] b [DATA_BEATS];
        logic          rw;
        for (int t = 0; t < n; t++) begin
            rw = ($urandom_range(0, 1) == 1);
            foreach (b[i]) b[i] = rnd_wide();
            do_req(rw, AW'($urandom()), TW'($urandom()), b);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic rnd_responses(input int n);
        for (int t = 0; t < n; t++) begin
            push_resp(TW'($urandom()), rnd_wide());
            repeat ($urandom_range(0, 6)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0]  zb [DATA_BEATS];
        logic [DW-1:0]  e;
        logic [AW-1:0]  ba;
        logic [TW-1:0]  bt;
        logic [HPW-1:0] h;

        foreach (zb[i]) zb[i] = '0;
        bus.narrow_req_valid    = 1'b0;
        bus.narrow_req_bits     = '0;
        bus.narrow_resp_ready   = 1'b1;
        bus.wide_req_cmd_ready  = 1'b1;
        bus.wide_req_data_ready = 1'b1;
        bus.wide_resp_valid     = 1'b0;
        bus.wide_resp_data      = '0;
        bus.wide_resp_tag       = '0;

        // Reset state
        #12;
        chk("rst_req_ready", bus.narrow_req_ready, 1);
        chk("rst_cmd_valid", bus.wide_req_cmd_valid, 0);
        chk("rst_data_valid", bus.wide_req_data_valid, 0);
        chk("rst_resp_valid", bus.narrow_resp_valid, 0);
        chk("rst_wresp_ready", bus.wide_resp_ready, 1);
        chk("rst_resp_bits", bus.narrow_resp_bits, 0);
        chk("rst_data_bits", bus.wide_req_data_bits, 0);
        chk("rst_cmd_addr", bus.wide_req_cmd_addr, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Read request with literal flits
        cmd_exp.push_back({5'd3, 26'h123, 1'b0});
        send_flit(16'h0246);
        send_flit(16'h1800);
        chk("rd_cmd_latency", bus.wide_req_cmd_valid, 1);
        drain_and_compare("rd");
        chk("rd_back_rx_hdr", bus.narrow_req_ready, 1);

        // Write request: 32 counting flits
        cmd_exp.push_back({5'd1, 26'h40, 1'b1});
        for (int b = 0; b < DATA_BEATS; b++) begin
            e = '0;
            for (int k = 0; k < DF; k++) e[k*NW +: NW] = NW'(b * DF + k);
            dat_exp.push_back(e);
        end
        send_flit(16'h0081);
        send_flit(16'h0800);
        for (int i = 0; i < DATA_BEATS * DF; i++) begin
            send_flit(NW'(i));
            if (i == DF - 1) chk("wr_data_latency", bus.wide_req_data_valid, 1);
        end
        drain_and_compare("wr");

        // Command backpressure
        ba = AW'($urandom());
        bt = TW'($urandom());
        bus.wide_req_cmd_ready = 1'b0;
        do_req(1'b0, ba, bt, zb);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_cmd_valid", bus.wide_req_cmd_valid, 1);
            chk("bp_cmd_fields", {bus.wide_req_cmd_tag, bus.wide_req_cmd_addr, bus.wide_req_cmd_rw}, {bt, ba, 1'b0});
            chk("bp_req_ready", bus.narrow_req_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.wide_req_cmd_ready = 1'b1;
        drain_and_compare("bp");

        // Response fill: 4 entries in the FIFO plus 1 in the serialiser
        bus.narrow_resp_ready = 1'b0;
        for (int r = 0; r < 5; r++) begin
            push_resp((r == 0) ? TW'(3) : TW'($urandom()), rnd_wide());
            if (r == 3) chk("fill_ready_before_full", bus.wide_resp_ready, 1);
            if (r == 4) chk("fill_ready_full", bus.wide_resp_ready, 0);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("fill_hold_valid", bus.narrow_resp_valid, 1);
            chk("fill_hold_bits", bus.narrow_resp_bits, rfl_exp[0]);
        end
        @(posedge clk);
        #1;
        bus.narrow_resp_ready = 1'b1;
        drain_and_compare("fill");

        // Asynchronous reset mid-transfer
        bus.narrow_resp_ready = 1'b0;
        push_resp(TW'(7), rnd_wide());
        h = HPW'({TW'(2), AW'(26'h155), 1'b1});
        for (int i = 0; i < HF; i++) send_flit(h[i*NW +: NW]);
        for (int i = 0; i < 3; i++) send_flit(NW'(16'hA0 + i));
        @(negedge clk);
        chk("mid_resp_valid_pre", bus.narrow_resp_valid, 1);
        chk("mid_req_ready_pre", bus.narrow_req_ready, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_resp_valid", bus.narrow_resp_valid, 0);
        chk("mid_rst_cmd_valid", bus.wide_req_cmd_valid, 0);
        chk("mid_rst_data_valid", bus.wide_req_data_valid, 0);
        chk("mid_rst_wresp_ready", bus.wide_resp_ready, 1);
        chk("mid_rst_resp_bits", bus.narrow_resp_bits, 0);
        clear_queues();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.narrow_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        cmd_exp.push_back({5'd3, 26'h123, 1'b0});
        send_flit(16'h0246);
        send_flit(16'h1800);
        drain_and_compare("post_rst");

        // Read in flight while two responses drain with ready toggling
        tog_mode = 1'b1;
        fork
            begin
                push_resp(TW'($urandom()), rnd_wide());
                push_resp(TW'($urandom()), rnd_wide());
            end
            do_req(1'b0, AW'($urandom()), TW'($urandom()), zb);
        join
        tog_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.narrow_resp_ready = 1'b1;
        drain_and_compare("conc");

        // Randomized traffic on both paths with random readies
        rnd_mode = 1'b1;
        fork
            rnd_requests(12);
            rnd_responses(10);
        join
        rnd_mode = 1'b0;
        @(posedge clk);
        #1;
        bus.wide_req_cmd_ready  = 1'b1;
        bus.wide_req_data_ready = 1'b1;
        bus.narrow_resp_ready   = 1'b1;
        drain_and_compare("rnd");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
